// File: rtl/life_pkg.sv
// Shared types for the Life display driver and its scan-capture counterpart.
package life_pkg;

    localparam int LIFE_N = 8;

    typedef logic [LIFE_N*LIFE_N-1:0] frame_t;

    typedef enum logic {
        SYNC,
        CAPTURE
    } capture_state_t;

    // Classification of a normalized row-select code.
    typedef enum logic [1:0] {
        ROW_BLANK,
        ROW_VALID,
        ROW_MULTI
    } row_class_t;

endpackage

// File: rtl/scan_settle_filter.sv
// Input register, polarity normalization, stability filter and row-code
// classifier for the multiplexed row/column scan lines. Emits a single-cycle
// event when a {row, col} pair has been stable for SETTLE_CYCLES samples.
module scan_settle_filter
    import life_pkg::*;
#(
    parameter int N               = LIFE_N,
    parameter int SETTLE_CYCLES   = 2,
    parameter int ROW_ACTIVE_HIGH = 1,
    parameter int COL_ACTIVE_HIGH = 1,
    localparam int RW             = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  rows_i,
    input  logic [N-1:0]  cols_i,
    output logic          evt_o,
    output row_class_t    evt_class_o,
    output logic [RW-1:0] evt_row_o,
    output logic [N-1:0]  evt_cols_o
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    logic [N-1:0]  row_q, col_q;
    logic [N-1:0]  prev_row_q, prev_col_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fire;
    row_class_t    cls;
    logic [RW-1:0] idx;
    int            ones;

    // Sample the scan lines once and convert them to active-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= (ROW_ACTIVE_HIGH != 0) ? rows_i : ~rows_i;
            col_q <= (COL_ACTIVE_HIGH != 0) ? cols_i : ~cols_i;
        end
    end

    // Dwell counter: restarts on any change, saturates once settled so a
    // held pair fires exactly once.
    always_comb begin
        cnt_d = cnt_q;
        fire  = 1'b0;
        if ({row_q, col_q} != {prev_row_q, prev_col_q}) begin
            cnt_d = CW'(1);
            fire  = (SETTLE_CYCLES == 1);
        end else if (cnt_q != CW'(SETTLE_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
            fire  = (cnt_q == CW'(SETTLE_CYCLES - 1));
        end
    end

    // Blank / one-hot / multi classification of the sampled row code.
    always_comb begin
        ones = 0;
        idx  = '0;
        for (int i = 0; i < N; i++) begin
            if (row_q[i]) begin
                ones = ones + 1;
                idx  = RW'(i);
            end
        end
        if (ones == 0)      cls = ROW_BLANK;
        else if (ones == 1) cls = ROW_VALID;
        else                cls = ROW_MULTI;
    end

    // Track previous sample and register the event with its payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_row_q  <= '0;
            prev_col_q  <= '0;
            cnt_q       <= CW'(SETTLE_CYCLES);
            evt_o       <= 1'b0;
            evt_class_o <= ROW_BLANK;
            evt_row_o   <= '0;
            evt_cols_o  <= '0;
        end else begin
            prev_row_q  <= row_q;
            prev_col_q  <= col_q;
            cnt_q       <= cnt_d;
            evt_o       <= fire;
            evt_class_o <= cls;
            evt_row_o   <= idx;
            evt_cols_o  <= col_q;
        end
    end

endmodule

// File: rtl/led_matrix_capture.sv
// Rebuilds full frames from the multiplexed 8x8 row/column scan of the Life
// display driver, checks scan order and row encoding, and publishes each
// completed frame with a one-cycle valid pulse.
// Optional feature macro: LIFE_CAPTURE_DIFF_EN adds frame_changed.
module led_matrix_capture
    import life_pkg::*;
#(
    parameter int N               = LIFE_N,
    parameter int SETTLE_CYCLES   = 2,
    parameter int ROW_ACTIVE_HIGH = 1,
    parameter int COL_ACTIVE_HIGH = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   rows_in,
    input  logic [N-1:0]   columns_in,
    output logic [N*N-1:0] frame_out,
    output logic           frame_valid,
    output logic           scan_error,
    output logic [15:0]    frame_count
`ifdef LIFE_CAPTURE_DIFF_EN
    ,
    output logic           frame_changed
`endif
);

    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic           evt;
    row_class_t     evt_class;
    logic [RW-1:0]  evt_row;
    logic [N-1:0]   evt_cols;

    capture_state_t state_q, state_d;
    logic [RW-1:0]  exp_row_q, exp_row_d;
    logic [N*N-1:0] shadow_q, shadow_d;
    logic [N*N-1:0] frame_q, frame_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic [15:0]    count_q, count_d;
`ifdef LIFE_CAPTURE_DIFF_EN
    logic           changed_q, changed_d;
`endif

    scan_settle_filter #(
        .N               (N),
        .SETTLE_CYCLES   (SETTLE_CYCLES),
        .ROW_ACTIVE_HIGH (ROW_ACTIVE_HIGH),
        .COL_ACTIVE_HIGH (COL_ACTIVE_HIGH)
    ) u_filter (
        .clk         (clk),
        .rst         (rst),
        .rows_i      (rows_in),
        .cols_i      (columns_in),
        .evt_o       (evt),
        .evt_class_o (evt_class),
        .evt_row_o   (evt_row),
        .evt_cols_o  (evt_cols)
    );

    // Frame assembly: next-state, shadow buffer and output updates.
    always_comb begin
        state_d   = state_q;
        exp_row_d = exp_row_q;
        shadow_d  = shadow_q;
        frame_d   = frame_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        count_d   = count_q;
`ifdef LIFE_CAPTURE_DIFF_EN
        changed_d = 1'b0;
`endif
        if (evt) begin
            case (state_q)
                SYNC: begin
                    if (evt_class == ROW_VALID && evt_row == '0) begin
                        shadow_d[0 +: N] = evt_cols;
                        exp_row_d        = RW'(1);
                        state_d          = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (evt_class == ROW_MULTI) begin
                        err_d     = 1'b1;
                        exp_row_d = '0;
                        state_d   = SYNC;
                    end else if (evt_class == ROW_VALID) begin
                        if (evt_row == exp_row_q) begin
                            shadow_d[int'(evt_row)*N +: N] = evt_cols;
                            if (evt_row == RW'(N - 1)) begin
                                frame_d   = shadow_d;
                                valid_d   = 1'b1;
                                count_d   = count_q + 16'd1;
                                exp_row_d = '0;
`ifdef LIFE_CAPTURE_DIFF_EN
                                changed_d = (shadow_d != frame_q);
`endif
                            end else begin
                                exp_row_d = exp_row_q + RW'(1);
                            end
                        end else begin
                            // Out of order; a row 0 restarts the frame at once.
                            err_d = 1'b1;
                            if (evt_row == '0) begin
                                shadow_d[0 +: N] = evt_cols;
                                exp_row_d        = RW'(1);
                            end else begin
                                exp_row_d = '0;
                                state_d   = SYNC;
                            end
                        end
                    end
                end
                default: state_d = SYNC;
            endcase
        end
    end

    // State, shadow buffer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SYNC;
            exp_row_q <= '0;
            shadow_q  <= '0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
`ifdef LIFE_CAPTURE_DIFF_EN
            changed_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            exp_row_q <= exp_row_d;
            shadow_q  <= shadow_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            count_q   <= count_d;
`ifdef LIFE_CAPTURE_DIFF_EN
            changed_q <= changed_d;
`endif
        end
    end

    assign frame_out   = frame_q;
    assign frame_valid = valid_q;
    assign scan_error  = err_q;
    assign frame_count = count_q;
`ifdef LIFE_CAPTURE_DIFF_EN
    assign frame_changed = changed_q;
`endif

endmodule
